// File: rtl/gr_access_if.sv
// Bus bundle between decode, register file, execute and the two writeback
// sources on one side and the gr_access controller on the other.
interface gr_access_if;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  // decode offer
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_rs1_n;
  logic [AW-1:0] id_rs2_n;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [AW-1:0] id_rd_n;
  logic          id_wr_rd;

  // register-file read ports
  logic          rs1;
  logic          rs2;
  logic [AW-1:0] rs1_n;
  logic [AW-1:0] rs2_n;
  logic [DW-1:0] s1_rd;
  logic [DW-1:0] s2_rd;

  // register-file write port
  logic          rd;
  logic [AW-1:0] rd_n;
  logic [DW-1:0] wd;

  // issue toward execute
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] ex_op1;
  logic [DW-1:0] ex_op2;
  logic [AW-1:0] ex_rd_n;
  logic          ex_wr_rd;

  // short and long writeback sources
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_rd_n;
  logic [DW-1:0] wb_data;
  logic          lwb_valid;
  logic [AW-1:0] lwb_rd_n;
  logic [DW-1:0] lwb_data;

  modport slave (
    input  id_valid, id_rs1_n, id_rs2_n, id_use_rs1, id_use_rs2, id_rd_n, id_wr_rd,
    output id_ready,
    output rs1, rs2, rs1_n, rs2_n,
    input  s1_rd, s2_rd,
    output rd, rd_n, wd,
    output ex_valid, ex_op1, ex_op2, ex_rd_n, ex_wr_rd,
    input  ex_ready,
    input  wb_valid, wb_rd_n, wb_data,
    output wb_ready,
    input  lwb_valid, lwb_rd_n, lwb_data
  );

  modport master (
    output id_valid, id_rs1_n, id_rs2_n, id_use_rs1, id_use_rs2, id_rd_n, id_wr_rd,
    input  id_ready,
    input  rs1, rs2, rs1_n, rs2_n,
    output s1_rd, s2_rd,
    input  rd, rd_n, wd,
    input  ex_valid, ex_op1, ex_op2, ex_rd_n, ex_wr_rd,
    output ex_ready,
    output wb_valid, wb_rd_n, wb_data,
    input  wb_ready,
    output lwb_valid, lwb_rd_n, lwb_data
  );
endinterface

// File: rtl/gr_access.sv
// Operand-fetch / writeback controller for the general-register file:
// busy scoreboard with optional same-cycle write bypass and one-stage issue.
module gr_access #(
  parameter bit BYPASS = 1'b1
) (
  input  logic       m_clock,
  input  logic       p_reset,
  gr_access_if.slave bus
);
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] beff;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;

  logic            sel_valid;
  logic [AW-1:0]   sel_n;
  logic [DW-1:0]   sel_data;
  logic            wr_en;

  logic            hazard;
  logic            ready;
  logic            accept;
  logic [DW-1:0]   op1;
  logic [DW-1:0]   op2;

  logic            ex_valid_q;
  logic [DW-1:0]   ex_op1_q;
  logic [DW-1:0]   ex_op2_q;
  logic [AW-1:0]   ex_rd_n_q;
  logic            ex_wr_rd_q;

  // Source is flagged when it reads/writes a nonzero register still pending.
  function automatic logic reg_hazard(input logic used, input logic [AW-1:0] idx,
                                      input logic [NREG-1:0] pend);
    return used & (idx != AW'(0)) & pend[idx];
  endfunction

  // x0 reads as zero; a same-cycle write to the source wins over the file.
  function automatic logic [DW-1:0] pick_operand(input logic used, input logic [AW-1:0] idx,
                                                 input logic [DW-1:0] rf_data);
    logic [DW-1:0] v;
    v = rf_data;
    if (!used || idx == AW'(0)) begin
      v = '0;
    end else if (BYPASS && wr_en && sel_n == idx) begin
      v = sel_data;
    end
    return v;
  endfunction

  // Read ports follow the decode bus directly.
  assign bus.rs1_n = bus.id_rs1_n;
  assign bus.rs2_n = bus.id_rs2_n;
  assign bus.rs1   = bus.id_valid & bus.id_use_rs1;
  assign bus.rs2   = bus.id_valid & bus.id_use_rs2;

  // Writeback arbitration: the long path cannot be back-pressured, so it wins.
  always_comb begin
    sel_valid = bus.lwb_valid | bus.wb_valid;
    sel_n     = bus.wb_rd_n;
    sel_data  = bus.wb_data;
    if (bus.lwb_valid) begin
      sel_n    = bus.lwb_rd_n;
      sel_data = bus.lwb_data;
    end
    wr_en = sel_valid & (sel_n != AW'(0));
  end

  assign bus.wb_ready = ~bus.lwb_valid;
  assign bus.rd       = wr_en;
  assign bus.rd_n     = sel_n;
  assign bus.wd       = sel_data;

  always_comb begin
    clr = '0;
    if (wr_en) begin
      clr[sel_n] = 1'b1;
    end
  end

  assign beff = BYPASS ? (busy & ~clr) : busy;

  always_comb begin
    hazard = reg_hazard(bus.id_use_rs1, bus.id_rs1_n, beff)
           | reg_hazard(bus.id_use_rs2, bus.id_rs2_n, beff)
           | reg_hazard(bus.id_wr_rd,   bus.id_rd_n,  beff);
    ready  = (~ex_valid_q | bus.ex_ready) & ~hazard;
    accept = bus.id_valid & ready;
  end

  assign bus.id_ready = ready;

  always_comb begin
    set = '0;
    if (accept && bus.id_wr_rd && bus.id_rd_n != AW'(0)) begin
      set[bus.id_rd_n] = 1'b1;
    end
  end

  always_comb begin
    op1 = pick_operand(bus.id_use_rs1, bus.id_rs1_n, bus.s1_rd);
    op2 = pick_operand(bus.id_use_rs2, bus.id_rs2_n, bus.s2_rd);
  end

  // Scoreboard: a new claim in the same cycle as a retiring write keeps the bit.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr) | set;
    end
  end

  // Issue register toward execute; holds while execute stalls.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      ex_valid_q <= 1'b0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_rd_n_q  <= '0;
      ex_wr_rd_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_op1_q   <= op1;
      ex_op2_q   <= op2;
      ex_rd_n_q  <= bus.id_rd_n;
      ex_wr_rd_q <= bus.id_wr_rd;
    end else if (bus.ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_op1   = ex_op1_q;
  assign bus.ex_op2   = ex_op2_q;
  assign bus.ex_rd_n  = ex_rd_n_q;
  assign bus.ex_wr_rd = ex_wr_rd_q;
endmodule

// File: tb/tb_gr_access.sv
// Bench for gr_access: a BYPASS=1 and a BYPASS=0 instance, a behavioural
// scoreboard model compared every cycle, plus directed literal checks.
module tb_gr_access;
  typedef struct packed {
    logic        idv;
    logic [4:0]  rs1n;
    logic [4:0]  rs2n;
    logic        u1;
    logic        u2;
    logic [4:0]  rdn;
    logic        wr;
    logic        exr;
    logic        wbv;
    logic [4:0]  wbn;
    logic [31:0] wbd;
    logic        lv;
    logic [4:0]  ln;
    logic [31:0] ld;
  } stim_t;

  typedef struct packed {
    logic        id_ready;
    logic        rs1;
    logic        rs2;
    logic [4:0]  rs1_n;
    logic [4:0]  rs2_n;
    logic        rd;
    logic [4:0]  rd_n;
    logic [31:0] wd;
    logic        wb_ready;
    logic        ex_valid;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [4:0]  ex_rd_n;
    logic        ex_wr_rd;
  } obs_t;

  typedef struct packed {
    logic [31:0] busy;
    logic        ev;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [4:0]  rn;
    logic        wr;
  } mst_t;

  logic m_clock = 1'b0;
  logic p_reset;
  int   tests = 0;
  int   fails = 0;

  always #5 m_clock = ~m_clock;

  gr_access_if ifa ();
  gr_access_if ifb ();

  gr_access #(.BYPASS(1'b1)) dut_a (.m_clock(m_clock), .p_reset(p_reset), .bus(ifa.slave));
  gr_access #(.BYPASS(1'b0)) dut_b (.m_clock(m_clock), .p_reset(p_reset), .bus(ifb.slave));

  stim_t sa;
  stim_t sb;

  assign ifa.id_valid = sa.idv;   assign ifb.id_valid = sb.idv;
  assign ifa.id_rs1_n = sa.rs1n;  assign ifb.id_rs1_n = sb.rs1n;
  assign ifa.id_rs2_n = sa.rs2n;  assign ifb.id_rs2_n = sb.rs2n;
  assign ifa.id_use_rs1 = sa.u1;  assign ifb.id_use_rs1 = sb.u1;
  assign ifa.id_use_rs2 = sa.u2;  assign ifb.id_use_rs2 = sb.u2;
  assign ifa.id_rd_n = sa.rdn;    assign ifb.id_rd_n = sb.rdn;
  assign ifa.id_wr_rd = sa.wr;    assign ifb.id_wr_rd = sb.wr;
  assign ifa.ex_ready = sa.exr;   assign ifb.ex_ready = sb.exr;
  assign ifa.wb_valid = sa.wbv;   assign ifb.wb_valid = sb.wbv;
  assign ifa.wb_rd_n = sa.wbn;    assign ifb.wb_rd_n = sb.wbn;
  assign ifa.wb_data = sa.wbd;    assign ifb.wb_data = sb.wbd;
  assign ifa.lwb_valid = sa.lv;   assign ifb.lwb_valid = sb.lv;
  assign ifa.lwb_rd_n = sa.ln;    assign ifb.lwb_rd_n = sb.ln;
  assign ifa.lwb_data = sa.ld;    assign ifb.lwb_data = sb.ld;

  // Register-file stand-in: unwritten entries read as C0DE00nn.
  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];
  logic [31:0] vld_a;
  logic [31:0] vld_b;

  function automatic logic [31:0] rfv(input logic v, input logic [31:0] d, input logic [4:0] i);
    return v ? d : (32'hC0DE_0000 | 32'(i));
  endfunction

  always @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      vld_a <= '0;
      vld_b <= '0;
    end else begin
      if (ifa.rd) begin vld_a[ifa.rd_n] <= 1'b1; regs_a[ifa.rd_n] <= ifa.wd; end
      if (ifb.rd) begin vld_b[ifb.rd_n] <= 1'b1; regs_b[ifb.rd_n] <= ifb.wd; end
    end
  end

  assign ifa.s1_rd = rfv(vld_a[ifa.rs1_n], regs_a[ifa.rs1_n], ifa.rs1_n);
  assign ifa.s2_rd = rfv(vld_a[ifa.rs2_n], regs_a[ifa.rs2_n], ifa.rs2_n);
  assign ifb.s1_rd = rfv(vld_b[ifb.rs1_n], regs_b[ifb.rs1_n], ifb.rs1_n);
  assign ifb.s2_rd = rfv(vld_b[ifb.rs2_n], regs_b[ifb.rs2_n], ifb.rs2_n);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: which register gets written, which registers are still owed a
  // result, and whether decode may proceed, from the controller's rules.
  function automatic void step(input stim_t s, input mst_t m, input bit byp,
                               input logic [31:0] d1, input logic [31:0] d2,
                               output obs_t x, output mst_t n);
    logic        wv;
    logic [4:0]  wn;
    logic [31:0] wdat;
    logic [31:0] owed;
    logic        haz;
    logic        acc;
    wv = 1'b0; wn = 5'd0; wdat = 32'd0;
    if (s.lv) begin wv = 1'b1; wn = s.ln; wdat = s.ld; end
    else if (s.wbv) begin wv = 1'b1; wn = s.wbn; wdat = s.wbd; end
    x = '0;
    x.wb_ready = !s.lv;
    x.rd       = wv && (wn != 5'd0);
    x.rd_n     = wn;
    x.wd       = wdat;
    x.rs1      = s.idv && s.u1;
    x.rs2      = s.idv && s.u2;
    x.rs1_n    = s.rs1n;
    x.rs2_n    = s.rs2n;
    owed = m.busy;
    if (byp && x.rd) owed[wn] = 1'b0;
    haz = (s.u1 && s.rs1n != 5'd0 && owed[s.rs1n]) ||
          (s.u2 && s.rs2n != 5'd0 && owed[s.rs2n]) ||
          (s.wr && s.rdn  != 5'd0 && owed[s.rdn]);
    x.id_ready = (!m.ev || s.exr) && !haz;
    x.ex_valid = m.ev;
    x.ex_op1   = m.o1;
    x.ex_op2   = m.o2;
    x.ex_rd_n  = m.rn;
    x.ex_wr_rd = m.wr;
    acc = s.idv && x.id_ready;
    n = m;
    if (x.rd) n.busy[wn] = 1'b0;
    if (acc && s.wr && s.rdn != 5'd0) n.busy[s.rdn] = 1'b1;
    if (acc) begin
      n.ev = 1'b1;
      n.o1 = (!s.u1 || s.rs1n == 5'd0) ? 32'd0 : (byp && x.rd && wn == s.rs1n) ? wdat : d1;
      n.o2 = (!s.u2 || s.rs2n == 5'd0) ? 32'd0 : (byp && x.rd && wn == s.rs2n) ? wdat : d2;
      n.rn = s.rdn;
      n.wr = s.wr;
    end else if (m.ev && s.exr) begin
      n.ev = 1'b0;
    end
  endfunction

  task automatic cmp(input string tag, input obs_t g, input obs_t x);
    chk({tag, ".id_ready"}, 32'(g.id_ready), 32'(x.id_ready));
    chk({tag, ".rs1"},      32'(g.rs1),      32'(x.rs1));
    chk({tag, ".rs2"},      32'(g.rs2),      32'(x.rs2));
    chk({tag, ".rs1_n"},    32'(g.rs1_n),    32'(x.rs1_n));
    chk({tag, ".rs2_n"},    32'(g.rs2_n),    32'(x.rs2_n));
    chk({tag, ".rd"},       32'(g.rd),       32'(x.rd));
    if (x.rd) begin
      chk({tag, ".rd_n"},   32'(g.rd_n),     32'(x.rd_n));
      chk({tag, ".wd"},     g.wd,            x.wd);
    end
    chk({tag, ".wb_ready"}, 32'(g.wb_ready), 32'(x.wb_ready));
    chk({tag, ".ex_valid"}, 32'(g.ex_valid), 32'(x.ex_valid));
    chk({tag, ".ex_op1"},   g.ex_op1,        x.ex_op1);
    chk({tag, ".ex_op2"},   g.ex_op2,        x.ex_op2);
    chk({tag, ".ex_rd_n"},  32'(g.ex_rd_n),  32'(x.ex_rd_n));
    chk({tag, ".ex_wr_rd"}, 32'(g.ex_wr_rd), 32'(x.ex_wr_rd));
  endtask

  mst_t ma, mb, na, nb;
  obs_t xa, xb, ga, gb;

  // Every-cycle comparison, midway between active edges.
  always @(negedge m_clock) begin
    if (p_reset) begin ma = '0; mb = '0; end
    step(sa, ma, 1'b1, rfv(vld_a[sa.rs1n], regs_a[sa.rs1n], sa.rs1n),
         rfv(vld_a[sa.rs2n], regs_a[sa.rs2n], sa.rs2n), xa, na);
    step(sb, mb, 1'b0, rfv(vld_b[sb.rs1n], regs_b[sb.rs1n], sb.rs1n),
         rfv(vld_b[sb.rs2n], regs_b[sb.rs2n], sb.rs2n), xb, nb);
    ga = '{ifa.id_ready, ifa.rs1, ifa.rs2, ifa.rs1_n, ifa.rs2_n, ifa.rd, ifa.rd_n, ifa.wd,
           ifa.wb_ready, ifa.ex_valid, ifa.ex_op1, ifa.ex_op2, ifa.ex_rd_n, ifa.ex_wr_rd};
    gb = '{ifb.id_ready, ifb.rs1, ifb.rs2, ifb.rs1_n, ifb.rs2_n, ifb.rd, ifb.rd_n, ifb.wd,
           ifb.wb_ready, ifb.ex_valid, ifb.ex_op1, ifb.ex_op2, ifb.ex_rd_n, ifb.ex_wr_rd};
    cmp("a", ga, xa);
    cmp("b", gb, xb);
    ma = p_reset ? '0 : na;
    mb = p_reset ? '0 : nb;
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.exr = 1'b1;
    return s;
  endfunction

  task automatic tick();
    @(posedge m_clock);
    #1;
  endtask

  task automatic probe();
    @(negedge m_clock);
  endtask

  initial begin
    p_reset = 1'b1;
    sa = idle();
    sb = idle();
    repeat (3) @(posedge m_clock);
    #1 p_reset = 1'b0;
    probe();
    chk("rst_ex_valid", 32'(ifa.ex_valid), 32'd0);
    chk("rst_ex_op1", ifa.ex_op1, 32'd0);
    chk("rst_id_ready", 32'(ifa.id_ready), 32'd1);

    // RAW on x1 resolved by same-cycle bypass
    tick(); sa = idle(); sa.idv = 1'b1; sa.wr = 1'b1; sa.rdn = 5'd1;
    probe(); chk("raw_first_accept", 32'(ifa.id_ready), 32'd1);
    tick(); sa = idle(); sa.idv = 1'b1; sa.u1 = 1'b1; sa.rs1n = 5'd1;
    probe(); chk("raw_stall0", 32'(ifa.id_ready), 32'd0);
    tick();
    probe(); chk("raw_stall1", 32'(ifa.id_ready), 32'd0);
    tick(); sa.wbv = 1'b1; sa.wbn = 5'd1; sa.wbd = 32'h1111_1111;
    probe(); chk("raw_bypass_ready", 32'(ifa.id_ready), 32'd1);
    chk("raw_wr_en", 32'(ifa.rd), 32'd1);
    tick(); sa = idle();
    probe(); chk("raw_op1", ifa.ex_op1, 32'h1111_1111);
    chk("raw_ex_valid", 32'(ifa.ex_valid), 32'd1);

    // both writeback sources at once
    tick(); sa = idle(); sa.lv = 1'b1; sa.ln = 5'd3; sa.ld = 32'hAAAA_0000;
    sa.wbv = 1'b1; sa.wbn = 5'd4; sa.wbd = 32'h0000_5555;
    probe(); chk("arb_rd_n", 32'(ifa.rd_n), 32'd3);
    chk("arb_wd", ifa.wd, 32'hAAAA_0000);
    chk("arb_wb_ready", 32'(ifa.wb_ready), 32'd0);
    tick(); sa.lv = 1'b0;
    probe(); chk("arb2_rd_n", 32'(ifa.rd_n), 32'd4);
    chk("arb2_wd", ifa.wd, 32'h0000_5555);
    chk("arb2_wb_ready", 32'(ifa.wb_ready), 32'd1);

    // x0 source and x0 writeback
    tick(); sa = idle(); sa.idv = 1'b1; sa.u1 = 1'b1; sa.rs1n = 5'd0;
    sa.u2 = 1'b1; sa.rs2n = 5'd2; sa.wbv = 1'b1; sa.wbn = 5'd0; sa.wbd = 32'hDEAD_BEEF;
    probe(); chk("x0_rd", 32'(ifa.rd), 32'd0);
    chk("x0_wb_ready", 32'(ifa.wb_ready), 32'd1);
    chk("x0_id_ready", 32'(ifa.id_ready), 32'd1);
    tick(); sa = idle();
    probe(); chk("x0_op1", ifa.ex_op1, 32'd0);
    chk("x0_op2", ifa.ex_op2, 32'hC0DE_0002);

    // execute back-pressure for three cycles
    tick(); sa = idle(); sa.idv = 1'b1; sa.u1 = 1'b1; sa.rs1n = 5'd2; sa.u2 = 1'b1; sa.rs2n = 5'd3;
    probe(); chk("bp_first_accept", 32'(ifa.id_ready), 32'd1);
    tick(); sa.exr = 1'b0; sa.rs1n = 5'd4; sa.rs2n = 5'd5;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick();
      probe();
      chk("bp_id_ready", 32'(ifa.id_ready), 32'd0);
      chk("bp_op1_hold", ifa.ex_op1, 32'hC0DE_0002);
      chk("bp_op2_hold", ifa.ex_op2, 32'hAAAA_0000);
    end
    tick(); sa.exr = 1'b1;
    probe(); chk("bp_release_ready", 32'(ifa.id_ready), 32'd1);
    tick(); sa = idle();
    probe(); chk("bp_next_op1", ifa.ex_op1, 32'h0000_5555);
    chk("bp_next_op2", ifa.ex_op2, 32'hC0DE_0005);

    // WAW on x5: new claim in the retire cycle keeps x5 busy
    tick(); sa = idle(); sa.idv = 1'b1; sa.wr = 1'b1; sa.rdn = 5'd5;
    probe(); chk("waw_first", 32'(ifa.id_ready), 32'd1);
    tick();
    probe(); chk("waw_stall0", 32'(ifa.id_ready), 32'd0);
    tick();
    probe(); chk("waw_stall1", 32'(ifa.id_ready), 32'd0);
    tick(); sa.lv = 1'b1; sa.ln = 5'd5; sa.ld = 32'h5555_5555;
    probe(); chk("waw_retire_ready", 32'(ifa.id_ready), 32'd1);
    tick(); sa = idle(); sa.idv = 1'b1; sa.u1 = 1'b1; sa.rs1n = 5'd5;
    probe(); chk("waw_still_busy", 32'(ifa.id_ready), 32'd0);
    tick(); sa.lv = 1'b1; sa.ln = 5'd5; sa.ld = 32'h5A5A_5A5A;
    probe(); chk("waw_read_ready", 32'(ifa.id_ready), 32'd1);
    tick(); sa = idle();
    probe(); chk("waw_read_op1", ifa.ex_op1, 32'h5A5A_5A5A);

    // reset in the middle of activity
    tick(); sa = idle(); sa.idv = 1'b1; sa.wr = 1'b1; sa.rdn = 5'd7;
    probe(); chk("mrst_claim", 32'(ifa.id_ready), 32'd1);
    tick(); sa = idle(); sa.exr = 1'b0;
    probe(); chk("mrst_ex_valid_pre", 32'(ifa.ex_valid), 32'd1);
    #2 p_reset = 1'b1;
    #1 chk("mrst_ex_valid", 32'(ifa.ex_valid), 32'd0);
    tick(); sa = idle();
    probe();
    tick(); p_reset = 1'b0; sa = idle(); sa.idv = 1'b1; sa.u1 = 1'b1; sa.rs1n = 5'd7;
    probe(); chk("mrst_busy_clear", 32'(ifa.id_ready), 32'd1);
    tick(); sa = idle();
    probe(); chk("mrst_op1", ifa.ex_op1, 32'hC0DE_0007);

    // no-bypass instance: acceptance waits for the write to land
    tick(); sb = idle(); sb.idv = 1'b1; sb.wr = 1'b1; sb.rdn = 5'd1;
    probe(); chk("nb_first", 32'(ifb.id_ready), 32'd1);
    tick(); sb = idle(); sb.idv = 1'b1; sb.u1 = 1'b1; sb.rs1n = 5'd1;
    probe(); chk("nb_stall", 32'(ifb.id_ready), 32'd0);
    tick(); sb.wbv = 1'b1; sb.wbn = 5'd1; sb.wbd = 32'h1111_1111;
    probe(); chk("nb_write_cycle_ready", 32'(ifb.id_ready), 32'd0);
    chk("nb_write_rd", 32'(ifb.rd), 32'd1);
    tick(); sb.wbv = 1'b0;
    probe(); chk("nb_after_write_ready", 32'(ifb.id_ready), 32'd1);
    tick(); sb = idle();
    probe(); chk("nb_op1", ifb.ex_op1, 32'h1111_1111);
    chk("nb_ex_valid", 32'(ifb.ex_valid), 32'd1);

    tick();
    probe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
